// File: rtl/posit_ccip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : posit_ccip_pkg
//  Purpose  : Shared types, constants and record packing for the posit
//             result path towards the CCI-P c1 write channel.
//  Revision : 1.0
// ============================================================================
package posit_ccip_pkg;

  localparam int REC_BYTES = 8;
  localparam int CL_BYTES  = 64;
  localparam int LANE_W    = 64;
  localparam int N_LANES   = CL_BYTES / REC_BYTES;

  // One 64-bit result record as it lands in host memory.
  typedef struct packed {
    logic [31:0] out;
    logic [18:0] rsvd_hi;
    logic        is_zero;
    logic        is_nar;
    logic        lt;
    logic        eq;
    logic        gt;
    logic [2:0]  rsvd_lo;
    logic [4:0]  exceptions;
  } t_result_rec;

  function automatic t_result_rec rec_pack(
    input logic [31:0] out,
    input logic        is_zero,
    input logic        is_nar,
    input logic        lt,
    input logic        eq,
    input logic        gt,
    input logic [4:0]  exceptions
  );
    t_result_rec r;
    r            = '0;
    r.out        = out;
    r.is_zero    = is_zero;
    r.is_nar     = is_nar;
    r.lt         = lt;
    r.eq         = eq;
    r.gt         = gt;
    r.exceptions = exceptions;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/posit_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : posit_result_fifo
//  Purpose  : Generic synchronous FIFO with full/empty flags. Pointers carry
//             one extra wrap bit so full and empty are distinguishable.
//  Revision : 1.0
// ============================================================================
module posit_result_fifo
  import posit_ccip_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]      wptr_q;
  logic [c_aw:0]      rptr_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               w_push;
  logic               w_pop;

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[c_aw] != rptr_q[c_aw]) &&
                   (wptr_q[c_aw-1:0] == rptr_q[c_aw-1:0]);
  assign dout_o  = mem_q[rptr_q[c_aw-1:0]];

  // Pointer update; reset empties the FIFO regardless of stored contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q[c_aw-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/posit_result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : posit_result_writer
//  Purpose  : Buffers FU result records, maps each to a host cache line and
//             byte lane, and issues CCI-P c1 byte-mode writes while tracking
//             the number of unacknowledged writes.
//  Revision : 1.0
// ============================================================================
module posit_result_writer
  import posit_ccip_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 32,
  parameter int CL_ADDR_W       = 42
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 cfg_valid,
  input  logic [CL_ADDR_W-1:0]                 cfg_base,
  input  logic [7:0]                           cfg_gran,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [7:0]                           in_wr_idx,
  input  logic [31:0]                          in_out,
  input  logic                                 in_is_zero,
  input  logic                                 in_is_nar,
  input  logic                                 in_lt,
  input  logic                                 in_eq,
  input  logic                                 in_gt,
  input  logic [4:0]                           in_exceptions,
  input  logic                                 c1_almost_full,
  output logic                                 c1_valid,
  output logic [CL_ADDR_W-1:0]                 c1_addr,
  output logic [5:0]                           c1_byte_start,
  output logic [5:0]                           c1_byte_len,
  output logic [15:0]                          c1_mdata,
  output logic [511:0]                         c1_data,
  input  logic                                 c1_rsp_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 idle,
  output logic                                 err_misaligned
);

  localparam int                c_out_w   = $clog2(MAX_OUTSTANDING+1);
  localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);
  localparam int                c_entry_w = CL_ADDR_W + 6 + LANE_W;

  // Configuration and status registers
  logic [CL_ADDR_W-1:0] cfg_base_q;
  logic [7:0]           cfg_gran_q;
  logic                 err_q;
  logic [15:0]          seq_q;
  logic [c_out_w-1:0]   outstanding_q;
  logic [c_out_w-1:0]   outstanding_d;

  // c1 request registers
  logic                 c1_valid_q;
  logic [CL_ADDR_W-1:0] c1_addr_q;
  logic [5:0]           c1_byte_start_q;
  logic [5:0]           c1_byte_len_q;
  logic [15:0]          c1_mdata_q;
  logic [511:0]         c1_data_q;

  // Enqueue-side datapath
  logic [15:0]          w_off;
  logic [CL_ADDR_W-1:0] w_line_addr;
  logic                 w_accept;
  logic                 w_aligned;
  t_result_rec          w_rec;
  logic [c_entry_w-1:0] w_entry_in;

  // Issue-side datapath
  logic [c_entry_w-1:0] w_head;
  logic [CL_ADDR_W-1:0] w_head_addr;
  logic [5:0]           w_head_off;
  logic [LANE_W-1:0]    w_head_rec;
  logic [511:0]         w_line_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_issue;
  logic                 w_rsp_take;

  assign w_off       = 16'(cfg_gran_q) * 16'(in_wr_idx);
  assign w_line_addr = cfg_base_q + CL_ADDR_W'(w_off[15:6]);
  assign w_aligned   = (w_off[2:0] == 3'b000);
  assign w_accept    = in_valid && in_ready;
  assign w_rec       = rec_pack(in_out, in_is_zero, in_is_nar, in_lt, in_eq,
                                in_gt, in_exceptions);
  assign w_entry_in  = {w_line_addr, w_off[5:0], w_rec};

  assign in_ready    = !w_fifo_full;

  posit_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (w_accept && w_aligned),
    .din_i   (w_entry_in),
    .pop_i   (w_issue),
    .dout_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign w_head_addr = w_head[c_entry_w-1 -: CL_ADDR_W];
  assign w_head_off  = w_head[LANE_W +: 6];
  assign w_head_rec  = w_head[LANE_W-1:0];

  // Place the record in the 64-bit lane chosen by offset bits [5:3].
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    assign w_line_data[l*LANE_W +: LANE_W] =
      (w_head_off[5:3] == 3'(l)) ? w_head_rec : '0;
  end

  assign w_issue    = !w_fifo_empty && !c1_almost_full &&
                      (outstanding_q < c_max_out);
  assign w_rsp_take = c1_rsp_valid && (outstanding_q != '0);

  // Outstanding count: issue and response in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (w_issue && !w_rsp_take) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!w_issue && w_rsp_take) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  // Configuration latch and sticky misalignment flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_base_q <= '0;
      cfg_gran_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (cfg_valid) begin
        cfg_base_q <= cfg_base;
        cfg_gran_q <= cfg_gran;
      end
      if (w_accept && !w_aligned) err_q <= 1'b1;
    end
  end

  // Register the c1 request for the entry popped this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c1_valid_q      <= 1'b0;
      c1_addr_q       <= '0;
      c1_byte_start_q <= '0;
      c1_byte_len_q   <= '0;
      c1_mdata_q      <= '0;
      c1_data_q       <= '0;
      seq_q           <= '0;
      outstanding_q   <= '0;
    end else begin
      c1_valid_q    <= w_issue;
      outstanding_q <= outstanding_d;
      if (w_issue) begin
        c1_addr_q       <= w_head_addr;
        c1_byte_start_q <= w_head_off;
        c1_byte_len_q   <= 6'(REC_BYTES);
        c1_mdata_q      <= seq_q;
        c1_data_q       <= w_line_data;
        seq_q           <= seq_q + 16'd1;
      end
    end
  end

  assign c1_valid       = c1_valid_q;
  assign c1_addr        = c1_addr_q;
  assign c1_byte_start  = c1_byte_start_q;
  assign c1_byte_len    = c1_byte_len_q;
  assign c1_mdata       = c1_mdata_q;
  assign c1_data        = c1_data_q;
  assign outstanding    = outstanding_q;
  assign err_misaligned = err_q;
  assign idle           = w_fifo_empty && (outstanding_q == '0) && !c1_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_posit_result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_posit_result_writer
//  Purpose  : Directed scoreboard bench for posit_result_writer.
//  Revision : 1.0
// ============================================================================
module tb_posit_result_writer;

  localparam int CLW = 42;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           cfg_valid;
  logic [CLW-1:0] cfg_base;
  logic [7:0]     cfg_gran;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     in_wr_idx;
  logic [31:0]    in_out;
  logic           in_is_zero, in_is_nar, in_lt, in_eq, in_gt;
  logic [4:0]     in_exceptions;
  logic           c1_almost_full;
  logic           c1_valid;
  logic [CLW-1:0] c1_addr;
  logic [5:0]     c1_byte_start;
  logic [5:0]     c1_byte_len;
  logic [15:0]    c1_mdata;
  logic [511:0]   c1_data;
  logic           c1_rsp_valid;
  logic [1:0]     outstanding;
  logic           idle;
  logic           err_misaligned;

  always #5 clk = ~clk;

  posit_result_writer #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .CL_ADDR_W       (CLW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_valid      (cfg_valid),
    .cfg_base       (cfg_base),
    .cfg_gran       (cfg_gran),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wr_idx      (in_wr_idx),
    .in_out         (in_out),
    .in_is_zero     (in_is_zero),
    .in_is_nar      (in_is_nar),
    .in_lt          (in_lt),
    .in_eq          (in_eq),
    .in_gt          (in_gt),
    .in_exceptions  (in_exceptions),
    .c1_almost_full (c1_almost_full),
    .c1_valid       (c1_valid),
    .c1_addr        (c1_addr),
    .c1_byte_start  (c1_byte_start),
    .c1_byte_len    (c1_byte_len),
    .c1_mdata       (c1_mdata),
    .c1_data        (c1_data),
    .c1_rsp_valid   (c1_rsp_valid),
    .outstanding    (outstanding),
    .idle           (idle),
    .err_misaligned (err_misaligned)
  );

  typedef struct {
    logic [CLW-1:0] addr;
    logic [5:0]     start;
    logic [15:0]    mdata;
    logic [511:0]   data;
  } exp_t;

  exp_t           sb[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             n_obs    = 0;
  logic [CLW-1:0] tb_base  = '0;
  logic [7:0]     tb_gran  = '0;
  logic [15:0]    tb_seq   = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [CLW-1:0] base, input logic [7:0] gran);
    cfg_valid = 1'b1;
    cfg_base  = base;
    cfg_gran  = gran;
    tb_base   = base;
    tb_gran   = gran;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  // Drive one record, wait for acceptance, and queue the expected request.
  task automatic push(input logic [7:0] idx, input logic [31:0] val,
                      input logic [4:0] flg, input logic [4:0] exc);
    logic [15:0]  off;
    logic [63:0]  rec;
    logic [511:0] d;
    exp_t         e;
    int           k;
    in_valid      = 1'b1;
    in_wr_idx     = idx;
    in_out        = val;
    {in_is_zero, in_is_nar, in_lt, in_eq, in_gt} = flg;
    in_exceptions = exc;
    k = 0;
    while (!in_ready && k < 200) begin
      tick(1);
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stuck at 0 for idx %0d", idx);
    end else begin
      off = 16'(tb_gran) * 16'(idx);
      rec = {val, 19'b0, flg, 3'b0, exc};
      d   = '0;
      d[off[5:3]*64 +: 64] = rec;
      if (off[2:0] == 3'b000) begin
        e.addr  = tb_base + CLW'(off[15:6]);
        e.start = off[5:0];
        e.mdata = tb_seq;
        e.data  = d;
        tb_seq  = tb_seq + 16'd1;
        sb.push_back(e);
      end
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  // Monitor: every presented request is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset_n && c1_valid) begin
      n_obs++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_c1: got request addr %0h, expected none", c1_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_addr",  64'(c1_addr),       64'(e.addr));
        chk("mon_start", 64'(c1_byte_start), 64'(e.start));
        chk("mon_len",   64'(c1_byte_len),   64'd8);
        chk("mon_mdata", 64'(c1_mdata),      64'(e.mdata));
        n_checks++;
        if (c1_data !== e.data) begin
          n_fail++;
          $display("FAIL mon_data: got %h expected %h", c1_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int obs0;
    reset_n        = 1'b0;
    cfg_valid      = 1'b0;
    cfg_base       = '0;
    cfg_gran       = '0;
    in_valid       = 1'b0;
    in_wr_idx      = '0;
    in_out         = '0;
    {in_is_zero, in_is_nar, in_lt, in_eq, in_gt} = 5'b0;
    in_exceptions  = '0;
    c1_almost_full = 1'b0;
    c1_rsp_valid   = 1'b0;
    tick(3);

    // Reset state
    chk("rst_c1_valid", 64'(c1_valid),       64'd0);
    chk("rst_in_ready", 64'(in_ready),       64'd1);
    chk("rst_idle",     64'(idle),           64'd1);
    chk("rst_outst",    64'(outstanding),    64'd0);
    chk("rst_err",      64'(err_misaligned), 64'd0);
    chk("rst_addr",     64'(c1_addr),        64'd0);
    chk("rst_len",      64'(c1_byte_len),    64'd0);
    chk("rst_mdata",    64'(c1_mdata),       64'd0);
    chk("rst_data",     64'(c1_data == 512'b0), 64'd1);
    reset_n = 1'b1;
    tick(1);

    // Basic record: lane 3 of the base line, two-cycle latency
    cfg(42'h1000, 8'd8);
    push(8'd3, 32'h4000_0000, 5'b00010, 5'h00);
    chk("t1_lat_n1", 64'(c1_valid), 64'd0);
    tick(1);
    chk("t1_lat_n2",  64'(c1_valid),        64'd1);
    chk("t1_addr",    64'(c1_addr),         64'h1000);
    chk("t1_start",   64'(c1_byte_start),   64'd24);
    chk("t1_lane3",   c1_data[255:192],     64'h4000_0000_0000_0200);
    chk("t1_mdata",   64'(c1_mdata),        64'd0);
    tick(2);

    // Offset crossing a line: gran 16, idx 5 -> off 80
    cfg(42'h1000, 8'd16);
    push(8'd5, 32'h3C00_0000, 5'b00001, 5'h03);
    tick(1);
    chk("t2_valid", 64'(c1_valid),      64'd1);
    chk("t2_addr",  64'(c1_addr),       64'h1001);
    chk("t2_start", 64'(c1_byte_start), 64'd16);
    chk("t2_lane2", c1_data[191:128],   64'h3C00_0000_0000_0103);
    tick(2);

    // Fresh start for back-pressure test
    reset_n = 1'b0;
    sb.delete();
    tb_seq = '0;
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Almost-full blocks issue; FIFO fills; responses held high throughout
    cfg(42'h2000, 8'd8);
    c1_almost_full = 1'b1;
    c1_rsp_valid   = 1'b1;
    obs0 = n_obs;
    fork
      begin
        for (int i = 0; i < 5; i++)
          push(8'(i), 32'h1000_0000 + 32'(i), 5'b10000, 5'(i));
      end
      begin
        tick(7);
        chk("t3_full_ready", 64'(in_ready),     64'd0);
        chk("t3_no_issue",   64'(n_obs - obs0), 64'd0);
        c1_almost_full = 1'b0;
      end
    join
    chk("t3_outst_same", 64'(outstanding), 64'd1);
    tick(10);
    chk("t3_issued",  64'(n_obs - obs0), 64'd5);
    chk("t3_drained", 64'(outstanding),  64'd0);
    c1_rsp_valid = 1'b0;

    // Misaligned record is dropped; error is sticky
    cfg(42'h3000, 8'd3);
    obs0 = n_obs;
    push(8'd1, 32'hDEAD_BEEF, 5'b00100, 5'h1F);
    tick(3);
    chk("t4_err",      64'(err_misaligned), 64'd1);
    chk("t4_no_issue", 64'(n_obs - obs0),   64'd0);
    push(8'd8, 32'h5555_AAAA, 5'b01000, 5'h11);
    tick(4);
    chk("t4_aligned",  64'(n_obs - obs0),   64'd1);
    chk("t4_err_hold", 64'(err_misaligned), 64'd1);
    c1_rsp_valid = 1'b1;
    tick(3);
    c1_rsp_valid = 1'b0;
    chk("t4_sat0", 64'(outstanding), 64'd0);

    // Outstanding limit of two
    cfg(42'h4000, 8'd8);
    obs0 = n_obs;
    for (int i = 0; i < 3; i++)
      push(8'(i), 32'h7000_0000 | 32'(i), 5'b00001, 5'h00);
    tick(8);
    chk("t5_outst_max", 64'(outstanding),  64'd2);
    chk("t5_two_only",  64'(n_obs - obs0), 64'd2);
    c1_rsp_valid = 1'b1;
    tick(1);
    c1_rsp_valid = 1'b0;
    tick(4);
    chk("t5_third",     64'(n_obs - obs0),   64'd3);
    chk("t5_outst_2",   64'(outstanding),    64'd2);
    chk("t5_err_still", 64'(err_misaligned), 64'd1);

    // Reset while FIFO holds two entries and writes are in flight
    c1_almost_full = 1'b1;
    push(8'd4, 32'h1111_1111, 5'b0, 5'h0);
    push(8'd5, 32'h2222_2222, 5'b0, 5'h0);
    tick(2);
    chk("t6_pre_valid", 64'(c1_valid), 64'd0);
    chk("t6_pre_idle",  64'(idle),     64'd0);
    #2;
    reset_n = 1'b0;
    sb.delete();
    tb_seq = '0;
    #1;
    chk("t6_valid", 64'(c1_valid),       64'd0);
    chk("t6_outst", 64'(outstanding),    64'd0);
    chk("t6_idle",  64'(idle),           64'd1);
    chk("t6_ready", 64'(in_ready),       64'd1);
    chk("t6_err",   64'(err_misaligned), 64'd0);
    @(posedge clk);
    #1;
    reset_n        = 1'b1;
    c1_almost_full = 1'b0;
    obs0 = n_obs;
    tick(10);
    chk("t6_no_stale", 64'(n_obs - obs0), 64'd0);
    chk("t6_idle_end", 64'(idle),         64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/posit_result_writer.md
Name: posit_result_writer

Overview:
- Downstream stage of the posit functional unit's mem_write port.
- Accepts result records from the FU and buffers them in a small FIFO.
- Computes the host cache-line address and byte lane for each record, then issues CCI-P c1 byte-mode write requests, honouring c1TxAlmFull.
- Tracks outstanding writes so the host side can tell when all results have landed.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 32, maximum issued-but-unacknowledged writes
CL_ADDR_W, 42, cache-line address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  latch cfg_base/cfg_gran this cycle
cfg_base  in  CL_ADDR_W  response region base (cache-line address)
cfg_gran  in  8  bytes per result slot
in_valid  in  1  FU result valid
in_ready  out  1  result accepted when in_valid && in_ready
in_wr_idx  in  8  result slot index
in_out  in  32  posit result
in_is_zero, in_is_nar, in_lt, in_eq, in_gt  in  1 each  result flags
in_exceptions  in  5  exception flags
c1_almost_full  in  1  host c1TxAlmFull
c1_valid  out  1  write request valid (one cycle per request)
c1_addr  out  CL_ADDR_W  line address
c1_byte_start  out  6  first byte written in the line
c1_byte_len  out  6  bytes written (always 8)
c1_mdata  out  16  request sequence tag
c1_data  out  512  line data
c1_rsp_valid  in  1  write-response pulse from host
outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight write count
idle  out  1  FIFO empty && outstanding==0 && c1_valid==0
err_misaligned  out  1  sticky: record dropped because its offset was not 8-byte aligned

Behaviour:
- Reset values: all outputs 0 except idle=1 and in_ready=1. cfg_base and cfg_gran reset to 0; FIFO pointers and counters reset to 0.
- Reset mid-operation discards the FIFO and the outstanding count; no further c1_valid is asserted after reset.
- Config: on cfg_valid, cfg_base and cfg_gran are registered. The change applies only to records enqueued on later cycles, never to records already in the FIFO.
- Enqueue:
  - Accept when in_valid && in_ready. in_ready = !full.
  - Byte offset: off[15:0] = cfg_gran * in_wr_idx, a full 16-bit product.
  - Line address: cfg_base + off[15:6], zero-extended, wrapping modulo 2^CL_ADDR_W.
  - Alignment: if off[2:0] != 0, the record is consumed but not stored, and err_misaligned is set (cleared only by reset).
  - Stored entry: {line_addr, off[5:0], rec64}.
- Record layout rec64: [63:32]=out, [31:13]=0, [12]=is_zero, [11]=is_nar, [10]=lt, [9]=eq, [8]=gt, [7:5]=0, [4:0]=exceptions.
- Issue condition: FIFO non-empty && !c1_almost_full && outstanding < MAX_OUTSTANDING.
- On issue, the head entry is popped. Next cycle the c1 outputs are registered:
  - c1_valid=1, c1_addr=line_addr, c1_byte_start=off[5:0], c1_byte_len=8
  - c1_data = rec64 placed in 64-bit lane off[5:3], all other lanes 0
  - c1_mdata = seq counter, which increments per issue and wraps at 16 bits
- Throughput and latency:
  - Sustained rate of one issue per cycle.
  - Latency: in_valid accepted at cycle N gives c1_valid at N+2 when the FIFO was empty (registered FIFO write, then registered issue).
  - c1_almost_full sampled high blocks issue in that cycle only; no requests are in flight inside the block.
- Simultaneous FIFO push and pop when full is not allowed, because in_ready=0 when full. Push and pop together when non-full leaves the count unchanged.
- Outstanding counter: +1 on issue, -1 on c1_rsp_valid.
  - Both in the same cycle leave it unchanged.
  - c1_rsp_valid while outstanding==0 is ignored; the counter saturates at 0.

Decomposition:
- Shared package posit_ccip_pkg:
  - t_result_rec packed struct (rec64 layout)
  - constants REC_BYTES=8, CL_BYTES=64, LANE_W=64
  - function rec_pack()
- Sub-module: posit_result_fifo, a generic synchronous FIFO (DEPTH, WIDTH) with full/empty and async active-low reset. The writer instantiates it.

Test Plan:
- cfg_base=0x1000, cfg_gran=8; push idx=3, out=0x40000000, eq=1 -> c1_valid at N+2, c1_addr=0x1000, c1_byte_start=24, c1_byte_len=8, c1_data[255:192]=0x40000000_00000200, other lanes 0, c1_mdata=0.
- cfg_gran=16, idx=5 -> off=80, c1_addr=base+1, c1_byte_start=16, data in lane 2.
- Hold c1_almost_full=1 and push 5 records with DEPTH=4 -> in_ready drops after 4 accepted, no c1_valid; release -> 4 consecutive c1_valid with mdata 0..3, then the 5th record is accepted and issued with mdata=4.
- cfg_gran=3, idx=1 -> no c1_valid, err_misaligned=1 and stays high; a later aligned record still issues.
- MAX_OUTSTANDING=2, push 3 records with no responses -> exactly 2 issues, outstanding=2; one c1_rsp_valid -> 3rd issues. Issue and response in the same cycle -> outstanding unchanged. Final responses -> idle=1.
- Deassert reset_n while the FIFO holds 2 entries -> c1_valid=0 immediately, outstanding=0, idle=1, and no stale issue after reset is released.
